uart_word_serializer: RTL and testbench

UART_WORD_SERIALIZER -- requirements
Module: uart_word_serializer

---
 rtl/uart_word_serializer.sv | 170 +++++++++++++++++
 tb/tb_uart_word_serializer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_serializer.sv
// Word-to-byte serializer: buffers whole words in a small FIFO and hands
// them to a byte-wide UART one byte at a time, LSB- or MSB-byte first.
module uart_word_serializer #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic                          iWordValid,
  input  logic [8*WORD_BYTES-1:0]       iWord,
  output logic                          oWordReady,
  input  logic                          iMsbFirst,
  input  logic                          iTxBusy,
  output logic [7:0]                    oUartTx8,
  output logic                          oByteTransmit,
  output logic                          oBusy,
  output logic [$clog2(FIFO_DEPTH):0]   oFifoLevel
);

  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned IDX_W  = $clog2(WORD_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    HOLD = 2'd3
  } tState;

  tState              state;
  tState              stateNext;

  logic [WORD_W-1:0]  fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   wrPtrNext;
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   rdPtrNext;
  logic [LVL_W-1:0]   level;
  logic [LVL_W-1:0]   levelNext;
  logic [WORD_W-1:0]  headWord;
  logic               doPush;
  logic               doPop;

  logic [WORD_W-1:0]  shiftReg;
  logic [WORD_W-1:0]  shiftNext;
  logic [WORD_W-1:0]  shifted;
  logic               msbLatched;
  logic               msbNext;
  logic [IDX_W-1:0]   byteIdx;
  logic [IDX_W-1:0]   byteIdxNext;

  logic [7:0]         txByteNext;
  logic               strobeNext;
  logic               busyNext;
  logic               readyNext;

  assign headWord   = fifoMem[rdPtr];
  assign oFifoLevel = level;

  // FIFO bookkeeping: pointers wrap naturally because the depth is a power of two
  always_comb begin
    doPush    = iWordValid && oWordReady;
    wrPtrNext = wrPtr;
    rdPtrNext = rdPtr;
    levelNext = level;
    if (doPush) begin
      wrPtrNext = wrPtr + PTR_W'(1);
    end
    if (doPop) begin
      rdPtrNext = rdPtr + PTR_W'(1);
    end
    if (doPush && !doPop) begin
      levelNext = level + LVL_W'(1);
    end else if (!doPush && doPop) begin
      levelNext = level - LVL_W'(1);
    end
  end

  // FSM next-state and datapath next values
  always_comb begin
    stateNext   = state;
    doPop       = 1'b0;
    shiftNext   = shiftReg;
    shifted     = shiftReg;
    msbNext     = msbLatched;
    byteIdxNext = byteIdx;
    txByteNext  = oUartTx8;
    strobeNext  = 1'b0;
    case (state)
      IDLE: begin
        if (level != LVL_W'(0)) begin
          stateNext = LOAD;
        end
      end
      LOAD: begin
        doPop       = 1'b1;
        shiftNext   = headWord;
        msbNext     = iMsbFirst;
        byteIdxNext = IDX_W'(0);
        txByteNext  = iMsbFirst ? headWord[WORD_W-1 -: 8] : headWord[7:0];
        stateNext   = SEND;
      end
      SEND: begin
        if (!iTxBusy) begin
          strobeNext = 1'b1;
          stateNext  = HOLD;
        end
      end
      HOLD: begin
        byteIdxNext = byteIdx + IDX_W'(1);
        shifted     = msbLatched ? (shiftReg << 8) : (shiftReg >> 8);
        shiftNext   = shifted;
        if (byteIdxNext == IDX_W'(WORD_BYTES)) begin
          stateNext = IDLE;
        end else begin
          txByteNext = msbLatched ? shifted[WORD_W-1 -: 8] : shifted[7:0];
          stateNext  = SEND;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Status outputs track the values the state and level take after this edge
  always_comb begin
    busyNext  = (stateNext != IDLE) || (levelNext != LVL_W'(0));
    readyNext = (levelNext != LVL_W'(FIFO_DEPTH));
  end

  // State, control and registered outputs
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state         <= IDLE;
      wrPtr         <= '0;
      rdPtr         <= '0;
      level         <= '0;
      shiftReg      <= '0;
      msbLatched    <= 1'b0;
      byteIdx       <= '0;
      oUartTx8      <= 8'h00;
      oByteTransmit <= 1'b0;
      oBusy         <= 1'b0;
      oWordReady    <= 1'b0;
    end else begin
      state         <= stateNext;
      wrPtr         <= wrPtrNext;
      rdPtr         <= rdPtrNext;
      level         <= levelNext;
      shiftReg      <= shiftNext;
      msbLatched    <= msbNext;
      byteIdx       <= byteIdxNext;
      oUartTx8      <= txByteNext;
      oByteTransmit <= strobeNext;
      oBusy         <= busyNext;
      oWordReady    <= readyNext;
    end
  end

  // Word storage; contents need no reset since the level gates every read
  always_ff @(posedge iClock) begin
    if (doPush) begin
      fifoMem[wrPtr] <= iWord;
    end
  end

endmodule

// File: tb/tb_uart_word_serializer.sv
// Scoreboard bench for uart_word_serializer: three builds (4, 1 and 8 bytes
// per word) share clock, reset, busy and byte-order inputs.
module tb_uart_word_serializer;

  logic        clock = 1'b0;
  logic        resetN;
  logic        msbFirst;
  logic        txBusy;

  logic        valid4, valid1, valid8;
  logic [31:0] word4;
  logic [7:0]  word1;
  logic [63:0] word8;
  logic        ready4, ready1, ready8;
  logic [7:0]  tx4, tx1, tx8;
  logic        stb4, stb1, stb8;
  logic        busy4, busy1, busy8;
  logic [2:0]  lvl4, lvl1, lvl8;

  uart_word_serializer #(.WORD_BYTES(4), .FIFO_DEPTH(4)) dut4 (
    .iClock(clock), .iReset(resetN), .iWordValid(valid4), .iWord(word4),
    .oWordReady(ready4), .iMsbFirst(msbFirst), .iTxBusy(txBusy),
    .oUartTx8(tx4), .oByteTransmit(stb4), .oBusy(busy4), .oFifoLevel(lvl4));

  uart_word_serializer #(.WORD_BYTES(1), .FIFO_DEPTH(4)) dut1 (
    .iClock(clock), .iReset(resetN), .iWordValid(valid1), .iWord(word1),
    .oWordReady(ready1), .iMsbFirst(msbFirst), .iTxBusy(txBusy),
    .oUartTx8(tx1), .oByteTransmit(stb1), .oBusy(busy1), .oFifoLevel(lvl1));

  uart_word_serializer #(.WORD_BYTES(8), .FIFO_DEPTH(4)) dut8 (
    .iClock(clock), .iReset(resetN), .iWordValid(valid8), .iWord(word8),
    .oWordReady(ready8), .iMsbFirst(msbFirst), .iTxBusy(txBusy),
    .oUartTx8(tx8), .oByteTransmit(stb8), .oBusy(busy8), .oFifoLevel(lvl8));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ4 [$];
  logic [7:0] expQ1 [$];
  logic [7:0] expQ8 [$];
  longint unsigned strobeT4 [$];
  int strobeCnt1 = 0;
  int strobeCnt8 = 0;
  longint unsigned tPush = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a word of nb bytes leaves as nb bytes, low byte first or high byte first
  function automatic void expPush(input int sel, input logic [63:0] w, input bit msb);
    int nb;
    int idx;
    nb = (sel == 0) ? 4 : ((sel == 1) ? 1 : 8);
    for (int k = 0; k < nb; k++) begin
      idx = msb ? (nb - 1 - k) : k;
      case (sel)
        0:       expQ4.push_back(w[8*idx +: 8]);
        1:       expQ1.push_back(w[8*idx +: 8]);
        default: expQ8.push_back(w[8*idx +: 8]);
      endcase
    end
  endfunction

  function automatic void popExp(input int sel, output bit have, output logic [7:0] b);
    have = 1'b0;
    b    = 8'h00;
    case (sel)
      0:       if (expQ4.size() != 0) begin have = 1'b1; b = expQ4.pop_front(); end
      1:       if (expQ1.size() != 0) begin have = 1'b1; b = expQ1.pop_front(); end
      default: if (expQ8.size() != 0) begin have = 1'b1; b = expQ8.pop_front(); end
    endcase
  endfunction

  // Monitor: every strobe pops and compares one expected byte
  task automatic monitor();
    logic       prevStb [3];
    logic       s;
    logic [7:0] t;
    logic [7:0] e;
    bit         have;
    for (int i = 0; i < 3; i++) prevStb[i] = 1'b0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        case (i)
          0:       begin s = stb4; t = tx4; end
          1:       begin s = stb1; t = tx1; end
          default: begin s = stb8; t = tx8; end
        endcase
        if (!resetN) begin
          prevStb[i] = 1'b0;
        end else begin
          if (s) begin
            check($sformatf("no back-to-back strobe dut%0d", i), prevStb[i], 0);
            popExp(i, have, e);
            if (!have) begin
              checks++;
              errors++;
              $display("FAIL unexpected strobe dut%0d: got byte %0h, expected no strobe", i, t);
            end else begin
              check($sformatf("byte dut%0d", i), t, e);
            end
            if (i == 0) strobeT4.push_back($time);
            else if (i == 1) strobeCnt1++;
            else strobeCnt8++;
          end
          prevStb[i] = s;
        end
      end
    end
  endtask

  // Offer one word for one cycle; returns whether it was accepted
  task automatic pushWord(input int sel, input logic [63:0] w, input bit msb, output bit acc);
    logic rdy;
    msbFirst = msb;
    case (sel)
      0:       begin valid4 = 1'b1; word4 = w[31:0]; rdy = ready4; end
      1:       begin valid1 = 1'b1; word1 = w[7:0];  rdy = ready1; end
      default: begin valid8 = 1'b1; word8 = w;       rdy = ready8; end
    endcase
    @(posedge clock);
    tPush = $time;
    acc = rdy;
    if (acc) expPush(sel, w, msb);
    @(negedge clock);
    #1;
    valid4 = 1'b0;
    valid1 = 1'b0;
    valid8 = 1'b0;
  endtask

  task automatic waitQ4(input int size);
    int n = 0;
    while (expQ4.size() > size && n < 500) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("wait for bytes", expQ4.size() > size, 0);
  endtask

  // Run until every expected byte has gone out, then confirm all builds are idle
  task automatic drain(input bit toggleMsb, input bit rndBusy);
    int n = 0;
    while ((expQ4.size() + expQ1.size() + expQ8.size()) != 0 && n < 3000) begin
      @(negedge clock);
      #1;
      n++;
      if (toggleMsb) msbFirst = ~msbFirst;
      if (rndBusy) txBusy = ($urandom_range(0, 3) == 0);
    end
    txBusy = 1'b0;
    check("drain remaining bytes", expQ4.size() + expQ1.size() + expQ8.size(), 0);
    @(negedge clock);
    #1;
    check("idle busy4", busy4, 0);
    check("idle busy1", busy1, 0);
    check("idle busy8", busy8, 0);
    check("idle level4", lvl4, 0);
  endtask

  task automatic stimulus();
    bit         acc;
    int         accCount;
    int         c1;
    int         c8;
    int         nStb;
    int         n;
    int         sel;
    bit         m;
    logic [63:0] w;

    // Reset values
    #12;
    check("reset ready", ready4, 0);
    check("reset strobe", stb4, 0);
    check("reset tx", tx4, 0);
    check("reset busy", busy4, 0);
    check("reset level", lvl4, 0);
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    #1;
    check("ready after reset dut4", ready4, 1);
    check("ready after reset dut1", ready1, 1);
    check("ready after reset dut8", ready8, 1);

    // LSB-first word with the UART always free
    strobeT4.delete();
    pushWord(0, 64'hA1B2C3D4, 1'b0, acc);
    check("accept first word", acc, 1);
    drain(1'b0, 1'b0);
    check("strobe count lsb word", strobeT4.size(), 4);
    if (strobeT4.size() == 4) begin
      check("first strobe latency at least 2 cycles", (strobeT4[0] - tPush) >= 20, 1);
      for (int i = 0; i < 3; i++)
        check($sformatf("strobe gap %0d", i), strobeT4[i+1] - strobeT4[i], 20);
    end

    // MSB-first word, byte-order input toggled while it is being sent
    pushWord(0, 64'hA1B2C3D4, 1'b1, acc);
    waitQ4(3);
    drain(1'b1, 1'b0);
    msbFirst = 1'b0;

    // UART busy for 10 cycles while byte C3 is pending
    pushWord(0, 64'hA1B2C3D4, 1'b0, acc);
    waitQ4(3);
    txBusy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      check($sformatf("no strobe while busy %0d", i), stb4, 0);
      check($sformatf("tx held while busy %0d", i), tx4, 8'hC3);
    end
    txBusy = 1'b0;
    @(negedge clock);
    #1;
    check("strobe when busy clears", stb4, 1);
    check("tx at release", tx4, 8'hC3);
    drain(1'b0, 1'b0);

    // FIFO fill: one word parked in the serializer, then six offered back-to-back
    txBusy = 1'b1;
    pushWord(0, 64'h11223344, 1'b0, acc);
    repeat (4) @(negedge clock);
    #1;
    accCount = 0;
    for (int i = 0; i < 6; i++) begin
      pushWord(0, 64'(32'hF0E0D000 + 32'(i)), 1'b0, acc);
      check($sformatf("accept pattern word %0d", i), acc, (i < 4) ? 1 : 0);
      if (acc) accCount++;
    end
    check("words accepted at full", accCount, 4);
    check("level at full", lvl4, 4);
    check("ready low at full", ready4, 0);
    txBusy = 1'b0;
    drain(1'b0, 1'b0);

    // 1-byte and 8-byte builds in both orders
    c1 = strobeCnt1;
    c8 = strobeCnt8;
    pushWord(1, 64'h5A, 1'b0, acc);
    pushWord(1, 64'hC3, 1'b1, acc);
    drain(1'b0, 1'b0);
    pushWord(2, 64'h0102030405060708, 1'b0, acc);
    drain(1'b0, 1'b0);
    pushWord(2, 64'h0102030405060708, 1'b1, acc);
    drain(1'b0, 1'b0);
    check("strobes for two 1-byte words", strobeCnt1 - c1, 2);
    check("strobes for two 8-byte words", strobeCnt8 - c8, 16);

    // Random bursts; byte order is only changed once everything has drained
    for (int b = 0; b < 8; b++) begin
      m = 1'($urandom_range(0, 1));
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) begin
        sel = int'($urandom_range(0, 2));
        w = {32'($urandom), 32'($urandom)};
        repeat ($urandom_range(0, 2)) @(negedge clock);
        #1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
          txBusy = ($urandom_range(0, 2) == 0);
          pushWord(sel, w, m, acc);
          n++;
        end
        check("random push accepted", acc, 1);
      end
      drain(1'b0, 1'b1);
    end

    // Reset in the middle of a word
    pushWord(0, 64'hA1B2C3D4, 1'b0, acc);
    waitQ4(2);
    #2;
    resetN = 1'b0;
    #1;
    check("mid-word reset strobe", stb4, 0);
    check("mid-word reset tx", tx4, 0);
    check("mid-word reset busy", busy4, 0);
    check("mid-word reset level", lvl4, 0);
    check("mid-word reset ready", ready4, 0);
    expQ4.delete();
    expQ1.delete();
    expQ8.delete();
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    #1;
    check("ready after mid-word reset", ready4, 1);
    nStb = strobeT4.size();
    repeat (20) @(negedge clock);
    #1;
    check("no strobes for discarded word", strobeT4.size() - nStb, 0);
    pushWord(0, 64'h55667788, 1'b1, acc);
    check("accept after reset", acc, 1);
    drain(1'b0, 1'b0);
  endtask

  initial begin
    resetN   = 1'b0;
    msbFirst = 1'b0;
    txBusy   = 1'b0;
    valid4   = 1'b0;
    valid1   = 1'b0;
    valid8   = 1'b0;
    word4    = '0;
    word1    = '0;
    word8    = '0;
    fork
      monitor();
      stimulus();
      begin
        repeat (60000) @(negedge clock);
        checks++;
        errors++;
        $display("FAIL watchdog: got no completion, expected stimulus to finish");
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
